// File: rtl/iir_first_order_mc.sv
// iir_first_order_mc: multi-channel saturating first-order IIR smoother y = x + (y_prev >>> SHIFT) with valid/ready
module iir_first_order_mc #(
    parameter int DW    = 8,
    parameter int NCH   = 4,
    parameter int CW    = 2,
    parameter int SHIFT = 1
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CW-1:0]        in_ch,
    input  logic signed [DW-1:0] inp,
    input  logic                 ic_load,
    input  logic signed [DW-1:0] in_cd,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CW-1:0]        out_ch,
    output logic signed [DW-1:0] out,
    output logic                 sat_flag
);
    logic signed [DW-1:0] st [NCH];
    logic signed [DW-1:0] fb;
    logic signed [DW-1:0] clip;
    logic [DW:0]          sum;
    logic                 ch_ok;
    logic                 acc;
    logic                 ovf;
    always_comb begin
        ch_ok    = {1'b0, in_ch} < (CW+1)'(NCH);
        in_ready = !ic_load && (!out_valid || out_ready);
        acc      = in_valid && in_ready && ch_ok;
        fb       = st[in_ch] >>> SHIFT;
        sum      = {inp[DW-1], inp} + {fb[DW-1], fb};
        ovf      = sum[DW] != sum[DW-1];
        clip     = ovf ? {sum[DW], {(DW-1){!sum[DW]}}} : sum[DW-1:0];
    end
    always_ff @(posedge clock) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) st[i] <= '0;
            out_valid <= 1'b0;
            out       <= '0;
            out_ch    <= '0;
            sat_flag  <= 1'b0;
        end else begin
            if (ic_load && ch_ok) st[in_ch] <= in_cd;
            if (acc) begin
                st[in_ch] <= clip;
                out       <= clip;
                out_ch    <= in_ch;
                sat_flag  <= ovf;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_iir_first_order_mc.sv
// tb_iir_first_order_mc: scoreboard bench for the multi-channel saturating IIR smoother
module tb_iir_first_order_mc;
    logic              clock = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [1:0]        in_ch = '0;
    logic signed [7:0] inp = '0;
    logic              ic_load = 1'b0;
    logic signed [7:0] in_cd = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [1:0]        out_ch;
    logic signed [7:0] out;
    logic              sat_flag;

    typedef struct {int ch; int v; int sat;} exp_t;
    exp_t q[$];
    int   s[4];
    int   total = 0;
    int   bad = 0;

    iir_first_order_mc #(.DW(8), .NCH(4), .CW(2), .SHIFT(1)) dut (
        .clock(clock), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_ch(in_ch), .inp(inp), .ic_load(ic_load), .in_cd(in_cd),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
        .out(out), .sat_flag(sat_flag)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int ch, input int x);
        exp_t e;
        int   raw;
        raw   = x + (s[ch] >>> 1);
        e.ch  = ch;
        e.sat = (raw > 127 || raw < -128) ? 1 : 0;
        e.v   = raw > 127 ? 127 : (raw < -128 ? -128 : raw);
        s[ch] = e.v;
        return e;
    endfunction

    task automatic send(input int ch, input int x);
        int n = 0;
        in_valid = 1'b1;
        in_ch    = 2'(ch);
        inp      = 8'(x);
        @(negedge clock);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clock);
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        @(posedge clock);
        if (in_ready) q.push_back(model(ch, x));
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_out", int'(out), 999);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out", int'(out), e.v);
                chk("out_ch", int'(out_ch), e.ch);
                chk("sat", int'(sat_flag), e.sat);
            end
        end
    end

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_out", int'(out), 0);
        chk("rst_ch", int'(out_ch), 0);
        chk("rst_sat", int'(sat_flag), 0);
        rst = 1'b0;
        foreach (s[i]) s[i] = 0;
        #1;
        chk("rst_ready", int'(in_ready), 1);

        send(0, 2); send(0, 4);
        chk("b2b_valid", int'(out_valid), 1);
        send(0, 6); send(0, 3);
        send(1, -3); send(1, 0);
        send(2, 0); send(0, 0);
        send(2, 127); send(2, 127);
        send(2, -128); send(2, -128); send(2, -128);
        idle(2);
        chk("drain1", q.size(), 0);

        in_valid = 1'b1; in_ch = 2'd3; inp = 8'sd2;
        ic_load = 1'b1; in_cd = 8'sd4;
        @(negedge clock);
        chk("ic_ready", int'(in_ready), 0);
        @(posedge clock);
        s[3] = 4;
        #1;
        ic_load = 1'b0;
        send(3, 2);
        idle(2);

        send(0, 2); send(1, 10); send(0, 4); send(1, 10);
        out_ready = 1'b0;
        in_valid = 1'b1; in_ch = 2'd2; inp = 8'sd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("stall_ready", int'(in_ready), 0);
            chk("stall_valid", int'(out_valid), 1);
            chk("stall_out", int'(out), q.size() > 0 ? q[0].v : 999);
        end
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        send(2, 5); send(3, -7); send(1, 1);
        idle(2);
        chk("drain2", q.size(), 0);

        send(0, 50); send(1, 20);
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clock);
        #1;
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_out", int'(out), 0);
        q.delete();
        foreach (s[i]) s[i] = 0;
        rst = 1'b0;
        send(0, 6); send(1, 2); send(2, -1); send(3, 8);
        idle(3);
        chk("drain3", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
